// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-buffered UART transmitter:
// FSM state encoding, parity codes and the bit-time divisor resolution.
package uart_tx_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   // A divisor of 0 selects the build-time default, and 1 is raised to 2 so
   // that the tx_done lookahead (one clock before the bit ends) always exists.
   function automatic logic [31:0] resolve_div(input logic [31:0] cfg, input logic [31:0] def_div);
      if (cfg == 32'd0)
         return def_div;
      else if (cfg == 32'd1)
         return 32'd2;
      return cfg;
   endfunction

   function automatic logic parity_en(input logic [1:0] par);
      return (par == PAR_ODD) || (par == PAR_EVEN);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync.sv
// Single-clock FIFO with first-word-fall-through read and registered
// full/empty/level flags; reports a dropped write one cycle later on ovf_o.
module uart_tx_fifo_sync #(
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       wrreq_i,
   input  logic [DW-1:0]              wdata_i,
   input  logic                       rd_i,
   output logic [DW-1:0]              rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       ovf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q, level_d;
   logic          full_q, empty_q, ovf_q;
   logic          wr_en, rd_en;

   always_comb begin
      wr_en   = wrreq_i && !full_q;
      rd_en   = rd_i && !empty_q;
      level_d = level_q;
      if (wr_en && !rd_en)
         level_d = level_q + 1'b1;
      else if (!wr_en && rd_en)
         level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
         full_q  <= (level_d == FULL_LVL);
         empty_q <= (level_d == '0);
         // Overflow is judged on the registered full flag, so a pop in the
         // same cycle does not rescue the dropped byte.
         ovf_q   <= wrreq_i && full_q;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = level_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: runtime divisor, 5..8 data bits,
// optional odd/even parity and 1 or 2 stop bits, frames sent back-to-back.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int FREQ     = 50_000_000,
   parameter int BAUDRATE = 115200,
   parameter int DW       = 8,
   parameter int DEPTH    = 16,
   parameter int DIV_W    = 16
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [DIV_W-1:0]        cfg_div,
   input  logic [1:0]              cfg_dbits,
   input  logic [1:0]              cfg_par,
   input  logic                    cfg_stop2,
   input  logic                    wrreq,
   input  logic [DW-1:0]           wdata,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    ovf,
   output logic                    tx,
   output logic                    busy,
   output logic                    tx_done
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(FREQ / BAUDRATE);

   logic            fifo_empty;
   logic [DW-1:0]   fifo_rdata;

   state_e          state_q;
   logic [DIV_W-1:0] div_cnt_q, div_q;
   logic [2:0]      bit_cnt_q;
   logic [DW-1:0]   data_q;
   logic [1:0]      dbits_q, par_q;
   logic            stop2_q, acc_q, tx_q, busy_q, done_q;

   logic [DIV_W-1:0] div_eff;
   logic            bit_end, last_data, last_stop, par_en, frame_end, pop, done_next;
   logic            cur_bit, next_bit;

   uart_tx_fifo_sync #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk     (clk),
      .nrst    (nrst),
      .wrreq_i (wrreq),
      .wdata_i (wdata),
      .rd_i    (pop),
      .rdata_o (fifo_rdata),
      .full_o  (full),
      .empty_o (fifo_empty),
      .level_o (level),
      .ovf_o   (ovf)
   );

   always_comb begin
      div_eff   = DIV_W'(resolve_div(32'(cfg_div), 32'(DEF_DIV)));
      bit_end   = (div_cnt_q == div_q - DIV_W'(1));
      last_data = (bit_cnt_q == ({1'b0, dbits_q} + 3'd4));
      last_stop = (bit_cnt_q[0] == stop2_q);
      par_en    = parity_en(par_q);
      cur_bit   = data_q[bit_cnt_q];
      next_bit  = data_q[bit_cnt_q + 3'd1];
      frame_end = (state_q == ST_STOP) && bit_end && last_stop;
      // Popping on the last stop clock lets the next start bit follow with no gap.
      pop       = !fifo_empty && ((state_q == ST_IDLE) || frame_end);
      done_next = (state_q == ST_STOP) && last_stop && (div_cnt_q == div_q - DIV_W'(2));
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= ST_IDLE;
         div_cnt_q <= '0;
         div_q     <= DIV_W'(2);
         bit_cnt_q <= '0;
         data_q    <= '0;
         dbits_q   <= '0;
         par_q     <= '0;
         stop2_q   <= 1'b0;
         acc_q     <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q    <= done_next;
         div_cnt_q <= div_cnt_q + DIV_W'(1);
         if (pop) begin
            state_q   <= ST_START;
            div_cnt_q <= '0;
            div_q     <= div_eff;
            bit_cnt_q <= '0;
            data_q    <= fifo_rdata;
            dbits_q   <= cfg_dbits;
            par_q     <= cfg_par;
            stop2_q   <= cfg_stop2;
            acc_q     <= 1'b0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  div_cnt_q <= '0;
               end
               ST_START: begin
                  if (bit_end) begin
                     state_q   <= ST_DATA;
                     div_cnt_q <= '0;
                     bit_cnt_q <= '0;
                     tx_q      <= data_q[0];
                  end
               end
               ST_DATA: begin
                  if (bit_end) begin
                     div_cnt_q <= '0;
                     acc_q     <= acc_q ^ cur_bit;
                     if (last_data) begin
                        bit_cnt_q <= '0;
                        if (par_en) begin
                           state_q <= ST_PARITY;
                           tx_q    <= acc_q ^ cur_bit ^ (par_q == PAR_ODD);
                        end else begin
                           state_q <= ST_STOP;
                           tx_q    <= 1'b1;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        tx_q      <= next_bit;
                     end
                  end
               end
               ST_PARITY: begin
                  if (bit_end) begin
                     state_q   <= ST_STOP;
                     div_cnt_q <= '0;
                     bit_cnt_q <= '0;
                     tx_q      <= 1'b1;
                  end
               end
               ST_STOP: begin
                  if (bit_end) begin
                     div_cnt_q <= '0;
                     if (last_stop) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule
